fifo_uart_tx: RTL
=================

# fifo_uart_tx

Downstream drain stage for the 8-deep × 8-bit synchronous FIFO. It pops one byte at a time whenever the FIFO is non-empty and transmission is enabled. Each byte is serialised onto a single UART line as an 8N1 frame, with optional even parity. It consumes the FIFO's `empty`/`dout` and drives its `rd_en`. It shares the FIFO's clock and reset.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit. Legal range is ≥2.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted between D7 and stop.
- `CNT_W`, default 16: width of the frame counter.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `tx_en`  in  1: permits starting a new frame. A frame already in progress always completes.
- `empty`  in  1: FIFO empty flag.
- `dout`  in  8: FIFO read data. It is valid the cycle after `rd_en` is sampled high (registered read).
- `rd_en`  out  1: FIFO pop strobe. It is combinational from the state register.
- `tx`  out  1: serial line, registered. It idles high.
- `busy`  out  1: high when state ≠ IDLE.
- `frame_done`  out  1: one-cycle pulse on the last cycle of the stop bit.
- `frames_sent`  out  CNT_W: count of completed frames. It wraps to 0 after all-ones.

## Operation
States:
- IDLE, LOAD, START, DATA, PARITY, STOP.
- PARITY exists only if `PARITY_EN`=1.

Transitions:
- IDLE: `rd_en` = `tx_en & ~empty`. If `rd_en`=1, go to LOAD; otherwise stay in IDLE.
- LOAD: capture `dout` into the shift register. Clear parity accumulator. Set `tx` to 0. Go to START.
- START: hold `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive bits LSB first, each for CLKS_PER_BIT cycles. A 3-bit index runs 0..7. After bit 7, go to PARITY if enabled, else to STOP.
- PARITY: drive `tx` = XOR of the 8 data bits. Hold for CLKS_PER_BIT cycles, then go to STOP.
- STOP: drive `tx`=1 for CLKS_PER_BIT cycles. On the final cycle, `frame_done`=1 and `frames_sent` increments; go to IDLE.

Rules:
- `rd_en` is high only in IDLE, and never for more than one consecutive cycle.
- `tx_en` deasserting mid-frame has no effect until IDLE is reached.
- Reset mid-frame:
  - The next cycle has `tx`=1 and IDLE state.
  - The byte in flight is discarded; the FIFO is reset by the same `rst`.
- The FIFO never pops while `empty`=1, whatever the value of `tx_en`.

## Timing
- Reset values: `tx`=1, `rd_en`=0, `busy`=0, `frame_done`=0, `frames_sent`=0, state=IDLE.
- Pop and start of frame:
  - Cycle N: IDLE with `empty`=0 and `tx_en`=1, so `rd_en`=1.
  - Cycle N+1: LOAD; `dout` is sampled at the end of N+1.
  - Cycle N+2: `tx` goes low (start bit).
- Frame length from start-bit edge to end of stop bit: (10+PARITY_EN)·CLKS_PER_BIT cycles.
- Back-to-back bytes: minimum 2 idle-high cycles (IDLE + LOAD) between a stop bit and the next start bit.
- Bit counter:
  - Counts 0..CLKS_PER_BIT−1.
  - Advances the bit index on terminal count.
  - Is cleared on every state change.

## Structure
- Package `uart_tx_pkg`:
  - `tx_state_t` enum: IDLE, LOAD, START, DATA, PARITY, STOP.
  - `DATA_W`=8.
  - `IDLE_LEVEL`=1'b1.
- Sub-module `uart_baud_cnt`:
  - Parameterised by CLKS_PER_BIT.
  - Inputs `clk`, `rst`, `clr`; output `tick` on terminal count.
  - Instantiated once.
- Top level holds the FSM, the 8-bit shift register, the bit index, the parity accumulator and `frames_sent`.

## Test plan
- Reset, then hold `empty`=1 for 50 cycles → `rd_en` stays 0, `tx` stays 1, `busy` stays 0.
- With CLKS_PER_BIT=4, push 8'hA5 → `rd_en` pulses once, `tx` low 2 cycles later.
  - Line pattern is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `frame_done` pulses and `frames_sent`=1.
- Fill the FIFO with 8 bytes 8'h00..8'h07 → 8 frames decode in order with exactly 2 idle cycles between frames. `frames_sent`=8 and `empty`=1 at the end.
- Assert `rst` in the middle of bit D3 → `tx`=1 and `busy`=0 on the next cycle. No `frame_done` pulse.
- Drop `tx_en` during a frame with 3 bytes queued → the current frame completes, no further `rd_en`. Re-raise `tx_en` → the remaining 3 frames are sent.
- With PARITY_EN=1, send 8'h07 → parity bit=1 and frame length is 44 cycles. Send 8'h03 → parity bit=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Imported by the baud counter and the top-level FSM.
package uart_tx_pkg;

    localparam int   DATA_W     = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// The FSM clears it on every state change so each bit cell starts at zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO one byte at a time and serialises each byte
// as an 8N1 UART frame, optionally with an even-parity bit before stop.
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout,
    output logic              rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frames_sent
);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [2:0]         r_bit_idx;
    logic               r_par;
    logic               r_tx;
    logic [CNT_W-1:0]   r_frames;
    logic               w_tick;
    logic               w_clr;
    logic               w_tx_next;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = IDLE_LEVEL;

        case (r_state)
            IDLE:   if (rd_en) w_state_next = LOAD;
            LOAD:   w_state_next = START;
            START:  if (w_tick) w_state_next = DATA;
            DATA:   if (w_tick && (r_bit_idx == 3'd7))
                        w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (w_tick) w_state_next = STOP;
            STOP:   if (w_tick) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // tx is registered, so it is driven from the level the next state needs.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = (r_state == DATA && w_tick) ? r_shift[1] : r_shift[0];
            // Entering PARITY, the accumulator has not yet folded in D7.
            PARITY:  w_tx_next = (r_state == DATA) ? (r_par ^ r_shift[0]) : r_par;
            default: w_tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= IDLE_LEVEL;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_frames  <= '0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            case (r_state)
                LOAD: begin
                    r_shift   <= dout;
                    r_par     <= 1'b0;
                    r_bit_idx <= '0;
                end
                DATA: if (w_tick) begin
                    r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                    r_par     <= r_par ^ r_shift[0];
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
                STOP: if (w_tick) r_frames <= r_frames + 1'b1;
                default: ;
            endcase
        end
    end

    assign w_clr       = (w_state_next != r_state);
    assign rd_en       = (r_state == IDLE) && tx_en && !empty;
    assign tx          = r_tx;
    assign busy        = (r_state != IDLE);
    assign frame_done  = (r_state == STOP) && w_tick;
    assign frames_sent = r_frames;

endmodule
